// File: rtl/pcileech_sys_ctl_pkg.sv
// Shared types and defaults for the system reset / button sequencer.
// Holds the FSM state encoding and counter sizing helper.
package pcileech_sys_ctl_pkg;

  typedef enum logic [1:0] {
    S_HOLD   = 2'd0,
    S_RUN    = 2'd1,
    S_PRESS  = 2'd2,
    S_RELOAD = 2'd3
  } sys_ctl_state_t;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 1000000;
  localparam int unsigned DEF_RST_HOLD_CYCLES = 64;
  localparam int unsigned DEF_RELOAD_CYCLES   = 500000000;
  localparam int unsigned DEF_BLINK_BIT       = 24;
  localparam int unsigned DEF_BLINK_WIN_BIT   = 27;

  // Counter width able to hold n-1, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pcileech_sys_ctl_debounce.sv
// Two-flop synchroniser and counter debouncer for one active-low button.
// pressed_o is high while the debounced button is held down.
module pcileech_sys_ctl_debounce
  import pcileech_sys_ctl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_n_i,
  output logic pressed_o
);

  localparam int unsigned CW = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic          deb_q, deb_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Synchroniser; both stages idle at released (1).
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sync_q <= 2'b11;
    else       sync_q <= {sync_q[0], btn_n_i};
  end

  // Count consecutive disagreeing cycles; accept on the last one.
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    if (sync_q[1] != deb_q) begin
      if (cnt_q == CNT_LAST) deb_d = sync_q[1];
      else                   cnt_d = cnt_q + CW'(1);
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      deb_q <= 1'b1;
      cnt_q <= '0;
    end else begin
      deb_q <= deb_d;
      cnt_q <= cnt_d;
    end
  end

  assign pressed_o = ~deb_q;

endmodule

// File: rtl/pcileech_sys_ctl.sv
// System reset sequencer: hold/run FSM, long-press config reload,
// power-on LED blink term and saturating 64-bit tick counter.
module pcileech_sys_ctl
  import pcileech_sys_ctl_pkg::*;
#(
  parameter int unsigned PARAM_DEBOUNCE_CYCLES  = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned PARAM_RST_HOLD_CYCLES  = DEF_RST_HOLD_CYCLES,
  parameter int unsigned PARAM_RELOAD_CYCLES    = DEF_RELOAD_CYCLES,
  parameter int unsigned PARAM_BLINK_BIT        = DEF_BLINK_BIT,
  parameter int unsigned PARAM_BLINK_WINDOW_BIT = DEF_BLINK_WIN_BIT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        user_sw1_n,
  input  logic        user_sw2_n,
  output logic        rst_sys,
  output logic        rst_cfg_reload,
  output logic        led_pwronblink,
  output logic [63:0] tickcount64
);

  localparam logic [63:0] HOLD_LAST  = 64'(PARAM_RST_HOLD_CYCLES - 1);
  localparam logic [31:0] PRESS_LAST = 32'(PARAM_RELOAD_CYCLES - 1);

  sys_ctl_state_t state_q, state_d;
  logic [63:0]    tick_q, tick_d;
  logic [31:0]    press_q, press_d;
  logic           rst_sys_q, rst_sys_d;
  logic           reload_q, reload_d;
  logic           led_q, led_d;
  logic           btn1_pressed, btn2_pressed;

  pcileech_sys_ctl_debounce #(
    .DEBOUNCE_CYCLES(PARAM_DEBOUNCE_CYCLES)
  ) u_deb_sw1 (
    .clk_i    (clk),
    .rst_i    (rst),
    .btn_n_i  (user_sw1_n),
    .pressed_o(btn1_pressed)
  );

  pcileech_sys_ctl_debounce #(
    .DEBOUNCE_CYCLES(PARAM_DEBOUNCE_CYCLES)
  ) u_deb_sw2 (
    .clk_i    (clk),
    .rst_i    (rst),
    .btn_n_i  (user_sw2_n),
    .pressed_o(btn2_pressed)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_HOLD;
    else     state_q <= state_d;
  end

  // Next state; a button-2 press beats the hold exit.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_HOLD: begin
        if (btn2_pressed)           state_d = S_PRESS;
        else if (tick_q == HOLD_LAST) state_d = S_RUN;
      end
      S_RUN: begin
        if (btn2_pressed) state_d = S_PRESS;
      end
      S_PRESS: begin
        if (!btn2_pressed)            state_d = S_HOLD;
        else if (press_q == PRESS_LAST) state_d = S_RELOAD;
      end
      S_RELOAD: begin
        if (!btn2_pressed) state_d = S_HOLD;
      end
      default: state_d = S_HOLD;
    endcase
  end

  // Tick and press counters; tick restarts from 0 out of a press.
  always_comb begin
    tick_d  = tick_q;
    press_d = '0;
    if (state_q inside {S_PRESS, S_RELOAD} || state_d == S_PRESS)
      tick_d = '0;
    else if (tick_q != '1)
      tick_d = tick_q + 64'd1;
    if (state_d inside {S_PRESS, S_RELOAD})
      press_d = (state_q == S_PRESS) ? press_q + 32'd1 : press_q;
  end

  // Output terms decoded from the next state and next tick.
  always_comb begin
    rst_sys_d = (state_d != S_RUN);
    reload_d  = (state_d == S_RELOAD);
    led_d     = btn1_pressed ^
                (tick_d[PARAM_BLINK_BIT] &
                 ~|tick_d[63:PARAM_BLINK_WINDOW_BIT]);
  end

  // Counter and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_q    <= '0;
      press_q   <= '0;
      rst_sys_q <= 1'b1;
      reload_q  <= 1'b0;
      led_q     <= 1'b0;
    end else begin
      tick_q    <= tick_d;
      press_q   <= press_d;
      rst_sys_q <= rst_sys_d;
      reload_q  <= reload_d;
      led_q     <= led_d;
    end
  end

  assign rst_sys        = rst_sys_q;
  assign rst_cfg_reload = reload_q;
  assign led_pwronblink = led_q;
  assign tickcount64    = tick_q;

endmodule

// File: tb/tb_pcileech_sys_ctl.sv
// Directed bench for pcileech_sys_ctl with small cycle parameters.
// Expected values are queued ahead of each check and popped on compare.
module tb_pcileech_sys_ctl;

  logic        clk = 1'b0;
  logic        rst;
  logic        sw1_n, sw2_n;
  logic        rst_sys, rst_cfg_reload, led_pwronblink;
  logic [63:0] tickcount64;

  pcileech_sys_ctl #(
    .PARAM_DEBOUNCE_CYCLES (4),
    .PARAM_RST_HOLD_CYCLES (8),
    .PARAM_RELOAD_CYCLES   (32),
    .PARAM_BLINK_BIT       (2),
    .PARAM_BLINK_WINDOW_BIT(4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .user_sw1_n    (sw1_n),
    .user_sw2_n    (sw2_n),
    .rst_sys       (rst_sys),
    .rst_cfg_reload(rst_cfg_reload),
    .led_pwronblink(led_pwronblink),
    .tickcount64   (tickcount64)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [63:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_run  = 0;
  int   n_fail = 0;

  task automatic push(input string tag, input logic [63:0] v);
    exp_t e;
    e.tag = tag;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic check(input logic [63:0] obs);
    exp_t e;
    n_run++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL sb_empty: observed %0d, no expectation queued", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) else begin
        n_fail++;
        $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic obs_sel(input int s);
    case (s)
      0:       return rst_sys;
      1:       return rst_cfg_reload;
      default: return led_pwronblink;
    endcase
  endfunction

  // Count edges until the selected output reaches v, bounded by lim.
  task automatic edges_until(input int s, input logic v,
                             input int lim, output int n);
    n = 0;
    while (obs_sel(s) !== v && n < lim) begin
      step(1);
      n++;
    end
  endtask

  function automatic logic blink(input int t);
    return ((t >> 2) & 1) == 1 && t < 16;
  endfunction

  initial begin
    int   n;
    logic seen;

    rst   = 1'b1;
    sw1_n = 1'b1;
    sw2_n = 1'b1;
    #1;
    push("rst_rst_sys", 1);  check(rst_sys);
    push("rst_reload", 0);   check(rst_cfg_reload);
    push("rst_led", 0);      check(led_pwronblink);
    push("rst_tick", 0);     check(tickcount64);
    step(3);

    rst = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      step(1);
      push("hold_tick", 64'(i));   check(tickcount64);
      push("hold_rst_sys", i < 8); check(rst_sys);
      push("blink_rel", blink(i)); check(led_pwronblink);
    end

    sw2_n = 1'b0;
    step(3);
    sw2_n = 1'b1;
    step(10);
    push("glitch_tick", 33);   check(tickcount64);
    push("glitch_rst_sys", 0); check(rst_sys);

    seen = 1'b0;
    sw2_n = 1'b0;
    edges_until(0, 1'b1, 50, n);
    push("press_lat", 7); check(n);
    for (int i = 0; i < 13; i++) begin
      step(1);
      if (rst_cfg_reload) seen = 1'b1;
      push("press_tick", 0); check(tickcount64);
    end
    sw2_n = 1'b1;
    edges_until(0, 1'b0, 50, n);
    push("release_lat", 15);   check(n);
    push("release_tick", 8);   check(tickcount64);
    push("short_reload", 0);   check(seen);

    sw1_n = 1'b0;
    step(10);
    push("led_inv_late", 1); check(led_pwronblink);

    seen = 1'b0;
    sw2_n = 1'b0;
    edges_until(0, 1'b1, 50, n);
    push("long_press_lat", 7); check(n);
    edges_until(1, 1'b1, 100, n);
    push("reload_lat", 32);    check(n);
    push("reload_rst_sys", 1); check(rst_sys);
    for (int i = 0; i < 21; i++) begin
      step(1);
      if (!rst_cfg_reload) seen = 1'b1;
    end
    push("reload_held", 0); check(seen);
    sw2_n = 1'b1;
    edges_until(1, 1'b0, 50, n);
    push("reload_fall_lat", 7); check(n);
    push("hold_after_rel", 1);  check(rst_sys);
    edges_until(0, 1'b0, 50, n);
    push("hold_len", 8);        check(n);
    push("hold_end_tick", 8);   check(tickcount64);
    for (int i = 9; i <= 20; i++) begin
      step(1);
      push("inv_tick", 64'(i));      check(tickcount64);
      push("blink_inv", !blink(i));  check(led_pwronblink);
    end

    sw2_n = 1'b0;
    edges_until(1, 1'b1, 200, n);
    push("reload2_lat", 39); check(n);
    rst = 1'b1;
    #1;
    push("async_reload", 0);  check(rst_cfg_reload);
    push("async_tick", 0);    check(tickcount64);
    push("async_rst_sys", 1); check(rst_sys);
    push("async_led", 0);     check(led_pwronblink);
    sw2_n = 1'b1;
    sw1_n = 1'b1;
    step(3);
    rst = 1'b0;
    edges_until(0, 1'b0, 50, n);
    push("rerelease_hold", 8); check(n);
    push("rerelease_reload", 0); check(rst_cfg_reload);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
